imem_loader: RTL and testbench

- Writer side of the instruction-memory interface; the CPU's instruction fetch is the reader side.
- Receives a framed program image as a byte stream and assembles little-endian 32-bit instruction words.
- Writes each word into instruction memory at consecutive word addresses starting at 0.
- Holds the CPU (PC update and data-memory writes) until the image is loaded and verified, then releases it.

---
 rtl/imem_loader.sv | 128 ++++++++++++
 tb/tb_imem_loader.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream program loader: frames, assembles and writes 32-bit words
// into instruction memory, holding the CPU until the image verifies.
module imem_loader #(
  parameter int ADDR_W = 16,
  parameter int MAX_WORDS = 1024,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [15:0]       words_loaded
);

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR
  } state_t;

  state_t state, state_n;

  logic [15:0]       len;
  logic [1:0]        lane;
  logic [7:0]        csum;
  logic [23:0]       wbuf;
  logic [ADDR_W-1:0] widx;
  logic              fire;
  logic              wr_word;
  logic              last_word;
  logic [15:0]       len_n;
  logic [31:0]       widx_p1;

  assign in_ready  = (state != DONE) && (state != ERR);
  assign fire      = in_valid && in_ready;
  assign len_n     = {in_data, len[7:0]};
  assign widx_p1   = 32'(widx) + 32'd1;
  assign last_word = widx_p1 == 32'(len);
  assign cpu_hold  = ~load_done;

  always_comb begin
    state_n = state;
    wr_word = 1'b0;
    unique case (state)
      IDLE:
        if (fire && in_data == SYNC_BYTE)
          state_n = LEN_LO;
      LEN_LO:
        if (fire)
          state_n = LEN_HI;
      LEN_HI:
        if (fire) begin
          if (32'(len_n) > 32'(MAX_WORDS))
            state_n = ERR;
          else if (len_n == 16'd0)
            state_n = CSUM;
          else
            state_n = DATA;
        end
      DATA:
        if (fire && lane == 2'd3) begin
          wr_word = 1'b1;
          if (last_word)
            state_n = CSUM;
        end
      CSUM:
        if (fire)
          state_n = (in_data == csum) ? DONE : ERR;
      DONE: state_n = DONE;
      ERR:  state_n = ERR;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      len          <= '0;
      lane         <= '0;
      csum         <= '0;
      wbuf         <= '0;
      widx         <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
    end else begin
      state   <= state_n;
      imem_we <= wr_word;
      if (fire) begin
        unique case (state)
          LEN_LO: len[7:0] <= in_data;
          LEN_HI: begin
            len  <= len_n;
            lane <= '0;
            csum <= '0;
            widx <= '0;
          end
          DATA: begin
            csum <= csum ^ in_data;
            lane <= lane + 2'd1;
            // Lanes shift in from the top so lane 0 ends up in bits [7:0]
            wbuf <= {in_data, wbuf[23:8]};
          end
          default: ;
        endcase
      end
      if (wr_word) begin
        imem_addr    <= widx;
        imem_wdata   <= {in_data, wbuf};
        widx         <= widx + 1'b1;
        words_loaded <= words_loaded + 16'd1;
      end
      if (state_n == DONE)
        load_done <= 1'b1;
      if (state_n == ERR)
        load_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
// Frames are streamed byte by byte; write pulses are logged by a monitor.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        imem_we;
  logic [15:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  logic [15:0] words_loaded;

  int total = 0;
  int passed = 0;
  int npulse = 0;
  logic [15:0] p_addr [8];
  logic [31:0] p_data [8];

  // XOR of 13 00 50 00 93 00 10 00 is 8'hC0
  logic [7:0] frame [12] = '{8'hA5, 8'h02, 8'h00,
                             8'h13, 8'h00, 8'h50, 8'h00,
                             8'h93, 8'h00, 8'h10, 8'h00, 8'hC0};

  imem_loader dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we) begin
      if (npulse < 8) begin
        p_addr[npulse] = imem_addr;
        p_data[npulse] = imem_wdata;
      end
      npulse = npulse + 1;
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    tick(1);
    rst = 1'b0;
    npulse = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data = b;
    while (!in_ready && n < 20) begin
      tick(1);
      n++;
    end
    total++;
    if (n >= 20)
      $display("FAIL send_byte timeout: in_ready=%b required 1", in_ready);
    else
      passed++;
    tick(1);
    in_valid = 1'b0;
    if (gap) tick(1);
  endtask

  task automatic send_frame(input logic [7:0] last, input bit gap);
    for (int i = 0; i < 11; i++) send_byte(frame[i], gap);
    send_byte(last, gap);
  endtask

  task automatic test_reset();
    do_reset();
    total += 8;
    if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %b want 1", in_ready); else passed++;
    if (cpu_hold !== 1'b1) $display("FAIL rst_cpu_hold got %b want 1", cpu_hold); else passed++;
    if (imem_we !== 1'b0) $display("FAIL rst_we got %b want 0", imem_we); else passed++;
    if (imem_addr !== 16'h0) $display("FAIL rst_addr got %h want 0", imem_addr); else passed++;
    if (imem_wdata !== 32'h0) $display("FAIL rst_wdata got %h want 0", imem_wdata); else passed++;
    if (load_done !== 1'b0) $display("FAIL rst_done got %b want 0", load_done); else passed++;
    if (load_err !== 1'b0) $display("FAIL rst_err got %b want 0", load_err); else passed++;
    if (words_loaded !== 16'd0) $display("FAIL rst_words got %0d want 0", words_loaded); else passed++;
  endtask

  task automatic test_load(input bit gap, input bit noise);
    do_reset();
    if (noise) begin
      send_byte(8'h00, gap);
      send_byte(8'hFF, gap);
      send_byte(8'h3C, gap);
    end
    send_frame(8'hC0, gap);
    tick(2);
    total += 10;
    if (npulse !== 2) $display("FAIL load_pulses got %0d want 2", npulse); else passed++;
    if (p_addr[0] !== 16'd0) $display("FAIL load_addr0 got %h want 0", p_addr[0]); else passed++;
    if (p_data[0] !== 32'h00500013) $display("FAIL load_data0 got %h want 00500013", p_data[0]); else passed++;
    if (p_addr[1] !== 16'd1) $display("FAIL load_addr1 got %h want 1", p_addr[1]); else passed++;
    if (p_data[1] !== 32'h00100093) $display("FAIL load_data1 got %h want 00100093", p_data[1]); else passed++;
    if (words_loaded !== 16'd2) $display("FAIL load_words got %0d want 2", words_loaded); else passed++;
    if (load_done !== 1'b1) $display("FAIL load_done got %b want 1", load_done); else passed++;
    if (cpu_hold !== 1'b0) $display("FAIL load_hold got %b want 0", cpu_hold); else passed++;
    if (in_ready !== 1'b0) $display("FAIL load_ready got %b want 0", in_ready); else passed++;
    if (load_err !== 1'b0) $display("FAIL load_err got %b want 0", load_err); else passed++;
  endtask

  task automatic test_bad_csum();
    do_reset();
    send_frame(8'h00, 1'b0);
    tick(2);
    total += 5;
    if (npulse !== 2) $display("FAIL badcs_pulses got %0d want 2", npulse); else passed++;
    if (load_err !== 1'b1) $display("FAIL badcs_err got %b want 1", load_err); else passed++;
    if (load_done !== 1'b0) $display("FAIL badcs_done got %b want 0", load_done); else passed++;
    if (cpu_hold !== 1'b1) $display("FAIL badcs_hold got %b want 1", cpu_hold); else passed++;
    if (in_ready !== 1'b0) $display("FAIL badcs_ready got %b want 0", in_ready); else passed++;
  endtask

  task automatic test_oversize();
    do_reset();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h04, 1'b0);
    total += 4;
    if (in_ready !== 1'b0) $display("FAIL over_ready got %b want 0", in_ready); else passed++;
    tick(3);
    if (npulse !== 0) $display("FAIL over_pulses got %0d want 0", npulse); else passed++;
    if (load_err !== 1'b1) $display("FAIL over_err got %b want 1", load_err); else passed++;
    if (cpu_hold !== 1'b1) $display("FAIL over_hold got %b want 1", cpu_hold); else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 9; i++) send_byte(frame[i], 1'b0);
    tick(1);
    total += 7;
    if (npulse !== 1) $display("FAIL mid_pulses got %0d want 1", npulse); else passed++;
    // Reset collides with a valid sync byte; the byte must be dropped
    in_valid = 1'b1;
    in_data = 8'hA5;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    in_valid = 1'b0;
    npulse = 0;
    if (words_loaded !== 16'd0) $display("FAIL mid_words got %0d want 0", words_loaded); else passed++;
    if (imem_addr !== 16'd0) $display("FAIL mid_addr got %h want 0", imem_addr); else passed++;
    if (imem_wdata !== 32'h0) $display("FAIL mid_wdata got %h want 0", imem_wdata); else passed++;
    if (cpu_hold !== 1'b1) $display("FAIL mid_hold got %b want 1", cpu_hold); else passed++;
    if (in_ready !== 1'b1) $display("FAIL mid_ready got %b want 1", in_ready); else passed++;
    if (imem_we !== 1'b0) $display("FAIL mid_we got %b want 0", imem_we); else passed++;
    send_frame(8'hC0, 1'b0);
    tick(2);
    total += 6;
    if (npulse !== 2) $display("FAIL mid2_pulses got %0d want 2", npulse); else passed++;
    if (p_addr[0] !== 16'd0) $display("FAIL mid2_addr0 got %h want 0", p_addr[0]); else passed++;
    if (p_data[0] !== 32'h00500013) $display("FAIL mid2_data0 got %h want 00500013", p_data[0]); else passed++;
    if (p_addr[1] !== 16'd1) $display("FAIL mid2_addr1 got %h want 1", p_addr[1]); else passed++;
    if (p_data[1] !== 32'h00100093) $display("FAIL mid2_data1 got %h want 00100093", p_data[1]); else passed++;
    if (load_done !== 1'b1) $display("FAIL mid2_done got %b want 1", load_done); else passed++;
  endtask

  task automatic test_zero_len();
    do_reset();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    tick(2);
    total += 5;
    if (npulse !== 0) $display("FAIL zero_pulses got %0d want 0", npulse); else passed++;
    if (load_done !== 1'b1) $display("FAIL zero_done got %b want 1", load_done); else passed++;
    if (cpu_hold !== 1'b0) $display("FAIL zero_hold got %b want 0", cpu_hold); else passed++;
    if (load_err !== 1'b0) $display("FAIL zero_err got %b want 0", load_err); else passed++;
    if (words_loaded !== 16'd0) $display("FAIL zero_words got %0d want 0", words_loaded); else passed++;
  endtask

  initial begin
    tick(1);
    test_reset();
    test_load(1'b0, 1'b0);
    test_bad_csum();
    test_oversize();
    test_load(1'b1, 1'b1);
    test_reset_mid();
    test_zero_len();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
